// File: rtl/exp_accel_pkg.sv
// -----------------------------------------------------------------------------
// exp_accel_pkg
//   Definitions shared by the exponential-series accelerator front end:
//   default operand/result widths and the feeder FSM state encoding.
// -----------------------------------------------------------------------------
package exp_accel_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_RES_W  = 16;

  // The feeder is either waiting for work or waiting for the engine.
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } feeder_state_t;

  // Width of a 0..n counter
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// -----------------------------------------------------------------------------
// stream_fifo
//   Small synchronous FIFO. The head entry is always visible on 'head', so a
//   pop consumes the value the reader is looking at in that same cycle.
//   Pushing while full and popping while empty are ignored.
//
// Parameters
//   WIDTH  entry width
//   DEPTH  number of entries (power of two, >= 2)
//
// Ports
//   clk    system clock, rising edge
//   rst    synchronous active-high reset (pointers and level only)
//   push   write din at the tail
//   din    data to write
//   pop    discard the head entry
//   head   current head entry (undefined when empty)
//   full   level == DEPTH
//   empty  level == 0
//   level  current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module stream_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/exp_stream_feeder.sv
// -----------------------------------------------------------------------------
// exp_stream_feeder
//   Stream wrapper around the iterative series-evaluation engine. Operands
//   arrive on a valid/ready stream and are queued in a small FIFO. One at a
//   time they are launched into the engine (one-cycle eng_start, eng_x held
//   until eng_done), and each result is captured into an output register
//   presented on a valid/ready stream. Results leave strictly in operand order.
//
//   A launch only happens when the output register is free or being drained
//   in the same cycle, so a captured result is never overwritten.
//
//   Optional build macro ENGINE_TIMEOUT_EN adds a watchdog: if the engine does
//   not answer within TIMEOUT_CYC cycles of the launch, the operand is
//   dropped, the sticky timeout_err flag is raised and the feeder moves on.
//   Without the macro timeout_err is tied low and the feeder waits forever.
//
// Parameters
//   DATA_W       operand width
//   RES_W        result width
//   FIFO_DEPTH   input FIFO entries (power of two, >= 2)
//   TIMEOUT_CYC  watchdog limit in cycles (ENGINE_TIMEOUT_EN only)
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   in_valid     operand available
//   in_data      operand x
//   in_ready     FIFO not full
//   eng_start    one-cycle start pulse to engine
//   eng_x        operand to engine, stable from start until done
//   eng_done     one-cycle completion pulse from engine
//   eng_r        engine result, valid with eng_done
//   out_valid    result held in output register
//   out_data     result
//   out_ready    consumer accepts result
//   busy         engine operation in flight
//   fifo_level   FIFO occupancy
//   timeout_err  sticky watchdog flag
// -----------------------------------------------------------------------------
module exp_stream_feeder
  import exp_accel_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int RES_W       = DEF_RES_W,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [DATA_W-1:0]             in_data,
  output logic                          in_ready,
  output logic                          eng_start,
  output logic [DATA_W-1:0]             eng_x,
  input  logic                          eng_done,
  input  logic [RES_W-1:0]              eng_r,
  output logic                          out_valid,
  output logic [RES_W-1:0]              out_data,
  input  logic                          out_ready,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          timeout_err
);

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) ||
      (TIMEOUT_CYC < 1)) begin : g_bad_param
    $error("exp_stream_feeder: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT_CYC >= 1");
  end

  feeder_state_t     state;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              launch;
  logic              slot_free;

  // Input side: accept whenever the queue has room, no bypass path.
  assign in_ready  = !fifo_full;
  assign push      = in_valid && in_ready;

  // The output register can take a new result if it is empty now or is being
  // drained this cycle; the engine latency guarantees it will be by capture.
  assign slot_free = !out_valid || out_ready;
  assign launch    = (state == IDLE) && !fifo_empty && slot_free;

  stream_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (in_data),
    .pop   (launch),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

`ifdef ENGINE_TIMEOUT_EN
  localparam int TMO_W = cnt_width(TIMEOUT_CYC);

  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;

  // Expiry on the TIMEOUT_CYC-th WAIT cycle counted from the launch edge.
  assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
`else
  assign timeout_err = 1'b0;
`endif

  // Launch / capture control
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      eng_start <= 1'b0;
      eng_x     <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
`ifdef ENGINE_TIMEOUT_EN
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      eng_start <= 1'b0;

      // Drain first; a capture below in the same cycle re-asserts it.
      if (out_valid && out_ready) out_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (launch) begin
            eng_x     <= fifo_head;
            eng_start <= 1'b1;
            busy      <= 1'b1;
            state     <= WAIT;
`ifdef ENGINE_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
          end
        end

        WAIT: begin
          // A completion on the expiry cycle still counts as a result.
          if (eng_done) begin
            out_data  <= eng_r;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
`ifdef ENGINE_TIMEOUT_EN
          else if (tmo_hit) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exp_stream_feeder.sv
module tb_exp_stream_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        eng_start;
  logic [15:0] eng_x;
  logic        eng_done;
  logic [15:0] eng_r;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;
  logic        busy;
  logic [2:0]  fifo_level;
  logic        timeout_err;

  int n_chk  = 0;
  int n_pass = 0;
  int n_start = 0;
  int eng_mode = 0;       // 0: engine answers after 6 cycles, 1: never answers
  int spur_req = 0;       // bumped by the main sequence to request a stray eng_done
  int spur_seen = 0;
  logic [15:0] sb[$];

  always #5 clk = ~clk;

  exp_stream_feeder #(
    .DATA_W      (16),
    .RES_W       (16),
    .FIFO_DEPTH  (4),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .eng_start   (eng_start),
    .eng_x       (eng_x),
    .eng_done    (eng_done),
    .eng_r       (eng_r),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .busy        (busy),
    .fifo_level  (fifo_level),
    .timeout_err (timeout_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Engine model: result = x + 0x01B7, done 6 cycles after start.
  initial begin : engine_model
    logic [15:0] mx;
    eng_done = 1'b0;
    eng_r    = '0;
    forever begin
      @(negedge clk);
      if (spur_req != spur_seen) begin
        spur_seen = spur_req;
        eng_done  = 1'b1;
        eng_r     = 16'hDEAD;
        @(negedge clk);
        eng_done  = 1'b0;
      end else if (eng_start && eng_mode == 0) begin
        mx = eng_x;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check("start_one_cycle", eng_start, 0);
          check("eng_x_held", eng_x, mx);
          check("busy_in_wait", busy, 1);
        end
        eng_done = 1'b1;
        eng_r    = mx + 16'h01B7;
        @(negedge clk);
        eng_done = 1'b0;
      end
    end
  end

  // Scoreboard monitor
  initial begin : monitor
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (eng_start) n_start++;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL sb_unexpected: got out_data 0x%0h, expected no output", out_data);
        end else begin
          e = sb.pop_front();
          check("sb_result", out_data, e);
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic push(input logic [15:0] x, input logic [15:0] exp, input bit expect_out);
    int n;
    in_valid = 1'b1;
    in_data  = x;
    n = 0;
    while (!in_ready && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 500) begin
      n_chk++;
      $display("FAIL push_timeout: in_ready stayed 0, expected 1");
    end
    if (expect_out) sb.push_back(exp);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy || fifo_level != 0 || out_valid) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 3000) begin
      n_chk++;
      $display("FAIL drain_timeout: queue %0d busy %0d, expected drained", sb.size(), busy);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"},   in_ready, 1);
    check({tag, "_eng_start"},  eng_start, 0);
    check({tag, "_eng_x"},      eng_x, 0);
    check({tag, "_out_valid"},  out_valid, 0);
    check({tag, "_out_data"},   out_data, 0);
    check({tag, "_busy"},       busy, 0);
    check({tag, "_fifo_level"}, fifo_level, 0);
    check({tag, "_timeout"},    timeout_err, 0);
  endtask

  initial begin : main
    int n, s0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");
    rst = 1'b0;
    @(posedge clk); #1;

    // Single operation
    push(16'h0100, 16'h02B7, 1);
    check("single_level_after_push", fifo_level, 1);
    check("single_no_start_yet", eng_start, 0);
    @(posedge clk); #1;
    check("single_start", eng_start, 1);
    check("single_eng_x", eng_x, 16'h0100);
    check("single_busy", busy, 1);
    check("single_level_after_pop", fifo_level, 0);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("single_start_to_valid", n, 6);
    check("single_out_data", out_data, 16'h02B7);
    wait_idle();

    // Burst of five with the consumer always ready
    s0 = n_start;
    push(16'h0001, 16'h01B8, 1);
    push(16'h0010, 16'h01C7, 1);
    push(16'h1000, 16'h11B7, 1);
    push(16'hFFFF, 16'h01B6, 1);
    push(16'h0A0A, 16'h0BC1, 1);
    check("burst_level_full", fifo_level, 4);
    check("burst_in_ready_low", in_ready, 0);
    wait_idle();
    check("burst_start_count", n_start - s0, 5);

    // Back-pressure: output held, no further launch
    out_ready = 1'b0;
    s0 = n_start;
    push(16'h0100, 16'h02B7, 1);
    push(16'h0001, 16'h01B8, 1);
    push(16'h0010, 16'h01C7, 1);
    repeat (30) @(posedge clk);
    #1;
    check("bp_one_start", n_start - s0, 1);
    check("bp_out_valid", out_valid, 1);
    check("bp_out_data", out_data, 16'h02B7);
    check("bp_level", fifo_level, 2);
    check("bp_not_busy", busy, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_restart", eng_start, 1);
    check("bp_restart_x", eng_x, 16'h0001);
    wait_idle();

    // Stray done while idle and empty
    spur_req++;
    repeat (5) @(posedge clk);
    #1;
    check("spur_idle_valid", out_valid, 0);
    check("spur_idle_data", out_data, 16'h01C7);
    check("spur_idle_busy", busy, 0);

    // Reset two cycles into WAIT, then a late done
    eng_mode = 1;
    push(16'h1234, 16'h0000, 0);
    n = 0;
    while (!eng_start && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("rw_started", eng_start, 1);
    repeat (2) @(posedge clk);
    #1;
    check("rw_busy_before", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_vals("rw");
    spur_req++;
    repeat (5) @(posedge clk);
    #1;
    check("rw_late_done_valid", out_valid, 0);
    check("rw_late_done_data", out_data, 0);
    check("rw_late_done_busy", busy, 0);

`ifdef ENGINE_TIMEOUT_EN
    // Engine never answers: watchdog drops the operand and moves on
    push(16'h0001, 16'h0000, 0);
    push(16'h0010, 16'h01C7, 1);
    check("tmo_first_start", eng_start, 1);
    n = 0;
    while (!timeout_err && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("tmo_cycles", n, 8);
    check("tmo_busy_clear", busy, 0);
    check("tmo_no_valid", out_valid, 0);
    eng_mode = 0;
    @(posedge clk); #1;
    check("tmo_next_start", eng_start, 1);
    check("tmo_next_x", eng_x, 16'h0010);
    wait_idle();
    check("tmo_sticky", timeout_err, 1);
`else
    eng_mode = 0;
    check("no_tmo_flag", timeout_err, 0);
`endif

    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
